// File: rtl/ethernet_pkg.sv
// Shared definitions for the receive-side Ethernet frame checker.
//   - framing byte values and the CRC-32 residue of a frame with a correct FCS
//   - frame error codes and checker FSM state encoding
//   - crc32_next: one byte of reflected IEEE 802.3 CRC-32, LSB first
package ethernet_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE      = 8'h55;
  localparam logic [7:0]  SFD_BYTE           = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE        = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT           = 32'hFFFF_FFFF;
  // 0x04C11DB7 bit-reversed, for the LSB-first shift direction
  localparam logic [31:0] CRC_POLY_REFLECTED = 32'hEDB8_8320;
  localparam logic [2:0]  PREAMBLE_MAX       = 3'd7;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CRC      = 3'd1,
    ERR_RUNT     = 3'd2,
    ERR_OVERSIZE = 3'd3,
    ERR_PREAMBLE = 3'd4
  } frame_error_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DROP     = 2'd3
  } checker_state_t;

  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ethernet_crc32_byte.sv
// Registered byte-wide CRC-32 accumulator.
// Ports:
//   clock, reset    system clock, synchronous active-high reset (register -> all-ones)
//   clear           reload all-ones; wins over enable
//   enable          fold data into the register
//   data[7:0]       byte to fold in
//   crc_next[31:0]  register value with data folded in (combinational), so the caller can
//                   judge the final byte of a frame in the same cycle it clears the register
module ethernet_crc32_byte
  import ethernet_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] crc_q;

  assign crc_next = crc32_next(crc_q, data);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc_q <= CRC_INIT;
    end else if (enable) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/ethernet_frame_checker.sv
// Receive frame checker: strips preamble/SFD, checks CRC-32 over payload+FCS, strips the FCS
// through a 4-byte delay line and forwards payload. One status pulse per frame plus
// saturating good/bad frame counters.
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   in_data[8:0], in_data_valid   byte in [7:0], [8] = last byte of frame; one-cycle strobe
//   out_data, out_data_valid,     payload byte out, one clock after the causing input,
//   out_data_last                 last flag on the final payload byte
//   frame_status_valid,           end-of-frame pulse with verdict and error code
//   frame_good, frame_error_code
//   good_frame_count,             saturating frame counters
//   bad_frame_count
//
// state    | meaning
// IDLE     | between frames, waiting for the first preamble byte
// PREAMBLE | counting 0x55 bytes (max 7), waiting for SFD
// PAYLOAD  | after SFD: CRC, length count, delay line
// DROP     | discarding bytes until the end marker
module ethernet_frame_checker
  import ethernet_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [8:0]               in_data,
  input  logic                     in_data_valid,
  output logic [7:0]               out_data,
  output logic                     out_data_valid,
  output logic                     out_data_last,
  output logic                     frame_status_valid,
  output logic                     frame_good,
  output logic [2:0]               frame_error_code,
  output logic [COUNTER_WIDTH-1:0] good_frame_count,
  output logic [COUNTER_WIDTH-1:0] bad_frame_count
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CNT_W-1:0] BYTE_SAT = CNT_W'(MAX_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] MIN_LEN  = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_FRAME_BYTES);

  checker_state_t   state_q, state_d;
  logic [2:0]       pre_count_q, pre_count_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d, byte_count_inc;
  logic             drop_reportable_q, drop_reportable_d;
  // [0] newest, [3] oldest
  logic [3:0][7:0]  delay_q, delay_d;
  logic [2:0]       fill_q, fill_d;

  logic             crc_clear, crc_enable;
  logic [31:0]      crc_next;
  logic             emit, emit_last, status;
  frame_error_t     code_d;

  logic [7:0] in_byte;
  logic       in_last;
  assign in_byte = in_data[7:0];
  assign in_last = in_data[8];

  ethernet_crc32_byte u_crc (
    .clock    (clock),
    .reset    (reset),
    .clear    (crc_clear),
    .enable   (crc_enable),
    .data     (in_byte),
    .crc_next (crc_next)
  );

  assign byte_count_inc = (byte_count_q == BYTE_SAT) ? byte_count_q : byte_count_q + CNT_W'(1);

  always_comb begin
    state_d           = state_q;
    pre_count_d       = pre_count_q;
    byte_count_d      = byte_count_q;
    drop_reportable_d = drop_reportable_q;
    delay_d           = delay_q;
    fill_d            = fill_q;
    crc_clear         = 1'b0;
    crc_enable        = 1'b0;
    emit              = 1'b0;
    emit_last         = 1'b0;
    status            = 1'b0;
    code_d            = ERR_NONE;

    if (in_data_valid) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            if (in_byte == PREAMBLE_BYTE) begin
              state_d     = PREAMBLE;
              pre_count_d = 3'd1;
            end else begin
              state_d           = DROP;
              drop_reportable_d = 1'b0;
            end
          end
        end
        PREAMBLE: begin
          if (in_last) begin
            status = 1'b1;
            code_d = ERR_PREAMBLE;
          end else if (in_byte == PREAMBLE_BYTE && pre_count_q < PREAMBLE_MAX) begin
            pre_count_d = pre_count_q + 3'd1;
          end else if (in_byte == SFD_BYTE) begin
            state_d      = PAYLOAD;
            byte_count_d = '0;
          end else begin
            state_d           = DROP;
            drop_reportable_d = 1'b1;
          end
        end
        PAYLOAD: begin
          crc_enable   = 1'b1;
          byte_count_d = byte_count_inc;
          emit         = (fill_q == 3'd4);
          delay_d      = {delay_q[2:0], in_byte};
          fill_d       = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
          if (in_last) begin
            status    = 1'b1;
            emit_last = emit;
            if (byte_count_inc > MAX_LEN)        code_d = ERR_OVERSIZE;
            else if (byte_count_inc < MIN_LEN)   code_d = ERR_RUNT;
            else if (crc_next != CRC_RESIDUE)    code_d = ERR_CRC;
            else                                 code_d = ERR_NONE;
          end
        end
        DROP: begin
          if (in_last && drop_reportable_q) begin
            status = 1'b1;
            code_d = ERR_PREAMBLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Any end marker closes the frame; the last payload byte was already judged via crc_next.
      if (in_last) begin
        state_d   = IDLE;
        crc_clear = 1'b1;
        delay_d   = '0;
        fill_d    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      pre_count_q        <= '0;
      byte_count_q       <= '0;
      drop_reportable_q  <= 1'b0;
      delay_q            <= '0;
      fill_q             <= '0;
      out_data           <= '0;
      out_data_valid     <= 1'b0;
      out_data_last      <= 1'b0;
      frame_status_valid <= 1'b0;
      frame_good         <= 1'b0;
      frame_error_code   <= '0;
      good_frame_count   <= '0;
      bad_frame_count    <= '0;
    end else begin
      state_q            <= state_d;
      pre_count_q        <= pre_count_d;
      byte_count_q       <= byte_count_d;
      drop_reportable_q  <= drop_reportable_d;
      delay_q            <= delay_d;
      fill_q             <= fill_d;
      out_data           <= emit ? delay_q[3] : 8'h00;
      out_data_valid     <= emit;
      out_data_last      <= emit_last;
      frame_status_valid <= status;
      frame_good         <= status && (code_d == ERR_NONE);
      frame_error_code   <= status ? code_d : ERR_NONE;
      if (status) begin
        if (code_d == ERR_NONE) begin
          if (good_frame_count != '1) good_frame_count <= good_frame_count + COUNTER_WIDTH'(1);
        end else begin
          if (bad_frame_count != '1) bad_frame_count <= bad_frame_count + COUNTER_WIDTH'(1);
        end
      end
    end
  end

endmodule
